// File: rtl/j_mx_pkg.sv
// Shared definitions for the j_MX array-edge feeder.
package j_mx_pkg;

  localparam logic CMD_WEIGHT = 1'b0;
  localparam logic CMD_ACT    = 1'b1;
  localparam int   NUM_SLOTS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  function automatic int fn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/j_piso.sv
// Parallel-load shift-out register: DW lanes, one bit per lane per beat,
// with a down-counting beat counter and terminal-count flags.
module j_piso #(
  parameter int DW     = 2,
  parameter int LANE_W = 8,
  parameter int CW     = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [DW*LANE_W-1:0] i_lanes,
  input  logic [CW-1:0]        i_beats_m1,
  output logic [DW-1:0]        o_bits,
  output logic [CW-1:0]        o_cnt,
  output logic                 o_last,
  output logic                 o_last_n
);

  logic [DW*LANE_W-1:0] r_sh;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_n;

  // Next beat count: reload on a new command, count down while shifting.
  always_comb begin
    w_cnt_n = r_cnt;
    if (i_load) begin
      w_cnt_n = i_beats_m1;
    end else if (i_shift) begin
      w_cnt_n = r_cnt - CW'(1);
    end
  end

  // Shift register and counter. The whole vector shifts as one, so a lane's
  // top bit picks up its neighbour's LSB; that bit is never reached because a
  // command never shifts more than LANE_W-1 times.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_n;
      if (i_load) begin
        r_sh <= i_lanes;
      end else if (i_shift) begin
        r_sh <= r_sh >> 1;
      end
    end
  end

  // Current beat: bit 0 of every lane.
  always_comb begin
    o_bits = '0;
    for (int j = 0; j < DW; j++) begin
      o_bits[j] = r_sh[j*LANE_W];
    end
  end

  assign o_cnt    = r_cnt;
  assign o_last   = (r_cnt == '0);
  assign o_last_n = (w_cnt_n == '0);

endmodule

// File: rtl/j_mx_feeder.sv
// Array-edge transmitter: serializes weight/activation commands onto the
// j_MX cell row bus.
//
//  state     | meaning
//  ----------+-------------------------------------------------------
//  ST_IDLE   | no command in flight, ready for a new one
//  ST_LOAD_W | shifting weight chunks out, update_w_o on every beat
//  ST_STREAM | streaming activation bits, mac_en_o on the current slot
//
// The FSM and shift register run one cycle ahead of the registered bus
// outputs; cmd_ready is high while the final beat is being prepared, so a
// command taken then follows the final beat with no bubble.
module j_mx_feeder
  import j_mx_pkg::*;
#(
  parameter  int DATA_WIDTH = 2,
  parameter  int ACT_BITS   = 8,
  localparam int CMD_W      = fn_max(8, DATA_WIDTH*ACT_BITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_type,
  input  logic [CMD_W-1:0]      cmd_data,
  output logic [DATA_WIDTH-1:0] dataflow_o,
  output logic                  update_w_o,
  output logic [NUM_SLOTS-1:0]  clr_and_plus_one_o,
  output logic [NUM_SLOTS-1:0]  mac_en_o,
  output logic                  busy_o
);

  localparam int NW     = 8 / DATA_WIDTH;
  localparam int LANE_W = fn_max(ACT_BITS, NW);
  localparam int CW     = $clog2(LANE_W);
  localparam logic [CW-1:0] W_BEATS_M1 = CW'(NW - 1);
  localparam logic [CW-1:0] A_BEATS_M1 = CW'(ACT_BITS - 1);

  state_t                       r_state, w_state_n;
  logic [1:0]                   r_slot;
  logic                         r_cmd_ready;
  logic [DATA_WIDTH-1:0]        r_dataflow;
  logic                         r_update_w;
  logic [NUM_SLOTS-1:0]         r_clr;
  logic [NUM_SLOTS-1:0]         r_mac_en;
  logic                         r_busy;

  logic                         w_accept, w_load, w_shift, w_ready_n;
  logic [DATA_WIDTH*LANE_W-1:0] w_w_lanes, w_a_lanes, w_lanes;
  logic [CW-1:0]                w_beats_m1, w_cnt;
  logic [DATA_WIDTH-1:0]        w_bits;
  logic                         w_last, w_last_n;
  logic [NUM_SLOTS-1:0]         w_onehot;

  assign w_accept = cmd_valid & r_cmd_ready;
  assign w_onehot = NUM_SLOTS'(1) << r_slot;

  // Arrange the command word into per-lane bit strings. Weight chunk k lands
  // at bit k of every lane so both command types share one shifter.
  always_comb begin
    w_w_lanes = '0;
    w_a_lanes = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      for (int k = 0; k < NW; k++) begin
        w_w_lanes[j*LANE_W+k] = cmd_data[k*DATA_WIDTH+j];
      end
      w_a_lanes[j*LANE_W +: ACT_BITS] = cmd_data[j*ACT_BITS +: ACT_BITS];
    end
  end

  // Next-state, shifter control and next cmd_ready.
  always_comb begin
    w_state_n  = r_state;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_beats_m1 = A_BEATS_M1;
    w_lanes    = w_a_lanes;
    if (r_state != ST_IDLE) begin
      if (w_last) begin
        w_state_n = ST_IDLE;
      end else begin
        w_shift = 1'b1;
      end
    end
    if (w_accept) begin
      w_load = 1'b1;
      if (cmd_type == CMD_ACT) begin
        w_state_n = ST_STREAM;
      end else begin
        w_state_n  = ST_LOAD_W;
        w_beats_m1 = W_BEATS_M1;
        w_lanes    = w_w_lanes;
      end
    end
    w_ready_n = (w_state_n == ST_IDLE) | w_last_n;
  end

  j_piso #(
    .DW     (DATA_WIDTH),
    .LANE_W (LANE_W),
    .CW     (CW)
  ) u_piso (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_lanes    (w_lanes),
    .i_beats_m1 (w_beats_m1),
    .o_bits     (w_bits),
    .o_cnt      (w_cnt),
    .o_last     (w_last),
    .o_last_n   (w_last_n)
  );

  // State register; the slot advances once per completed activation word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_slot  <= 2'd0;
    end else begin
      r_state <= w_state_n;
      if (r_state == ST_STREAM && w_last) begin
        r_slot <= r_slot + 2'd1;
      end
    end
  end

  // Registered bus outputs for the beat prepared in the current state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_ready <= 1'b1;
      r_dataflow  <= '0;
      r_update_w  <= 1'b0;
      r_clr       <= '0;
      r_mac_en    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_ready <= w_ready_n;
      r_dataflow  <= (r_state != ST_IDLE) ? w_bits : '0;
      r_update_w  <= (r_state == ST_LOAD_W);
      r_mac_en    <= (r_state == ST_STREAM) ? w_onehot : '0;
      r_clr       <= (r_state == ST_STREAM && w_cnt == A_BEATS_M1) ? w_onehot : '0;
      r_busy      <= (r_state != ST_IDLE);
    end
  end

  assign cmd_ready          = r_cmd_ready;
  assign dataflow_o         = r_dataflow;
  assign update_w_o         = r_update_w;
  assign clr_and_plus_one_o = r_clr;
  assign mac_en_o           = r_mac_en;
  assign busy_o             = r_busy;

endmodule
